// File: rtl/serial_uart_pkg.sv
// rtl/serial_uart_pkg.sv - shared FSM state encoding and UART framing constants
package serial_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO; a pop frees room for a same-cycle push
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  pushData,
    input  logic          pop,
    output logic [W-1:0]  popData,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + (AW + 1)'(doPush) - (AW + 1)'(doPop);
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// rtl/serial_uart_bridge.sv - processor serial port to 8N1 UART bridge with TX/RX FIFOs
module serial_uart_bridge
    import serial_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wren_in,
    output logic       cpu_ready_out,
    output logic [7:0] cpu_data_out,
    output logic       cpu_valid_out,
    input  logic       cpu_rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_frame_err_out,
    output logic       rx_overrun_out
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_CNT = CW'(CLKS_PER_BIT / 2);
    localparam int              IW       = $clog2(UART_DATA_BITS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(UART_DATA_BITS - 1);

    // ---------------- transmit path ----------------
    logic                       txEmpty;
    logic                       txFull;
    logic [7:0]                 txHead;
    logic                       txPush;
    logic                       txPop;
    logic [FIFO_AW:0]           unusedTxCount;
    uart_state_t                txState;
    logic [CW-1:0]              txCnt;
    logic [IW-1:0]              txIdx;
    logic [UART_DATA_BITS-1:0]  txShift;
    logic                       txLine;

    assign cpu_ready_out = !txFull;
    assign txPush        = cpu_wren_in && cpu_ready_out;
    assign txPop         = (txState == IDLE) && !txEmpty;
    assign uart_tx_out   = txLine;

    sync_fifo #(.W(8), .AW(FIFO_AW)) txFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (txPush),
        .pushData (cpu_data_in),
        .pop      (txPop),
        .popData  (txHead),
        .full     (txFull),
        .empty    (txEmpty),
        .count    (unusedTxCount)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            txState <= IDLE;
            txCnt   <= '0;
            txIdx   <= '0;
            txShift <= '0;
            txLine  <= LINE_IDLE;
        end else begin
            case (txState)
                IDLE: begin
                    if (!txEmpty) begin
                        txShift <= txHead;
                        txCnt   <= '0;
                        txState <= START;
                    end
                end
                START: begin
                    if (txCnt == LAST_CNT) begin
                        txCnt   <= '0;
                        txIdx   <= '0;
                        txState <= DATA;
                    end else begin
                        txCnt <= txCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (txCnt == LAST_CNT) begin
                        txCnt   <= '0;
                        txShift <= txShift >> 1;
                        if (txIdx == LAST_IDX) begin
                            txState <= STOP;
                        end else begin
                            txIdx <= txIdx + IW'(1);
                        end
                    end else begin
                        txCnt <= txCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (txCnt == LAST_CNT) begin
                        txCnt   <= '0;
                        txState <= IDLE;
                    end else begin
                        txCnt <= txCnt + CW'(1);
                    end
                end
                default: txState <= IDLE;
            endcase

            // Line is registered from the state, so it trails the FSM by one cycle.
            case (txState)
                START:   txLine <= 1'b0;
                DATA:    txLine <= txShift[0];
                default: txLine <= LINE_IDLE;
            endcase
        end
    end

    // ---------------- receive path ----------------
    logic                       rxMeta;
    logic                       rxSync;
    logic                       rxPrev;
    uart_state_t                rxState;
    logic [CW-1:0]              rxCnt;
    logic [IW-1:0]              rxIdx;
    logic [UART_DATA_BITS-1:0]  rxShift;
    logic                       rxEmpty;
    logic                       rxFull;
    logic [7:0]                 rxHead;
    logic [FIFO_AW:0]           unusedRxCount;
    logic                       stopSample;
    logic                       rxPush;
    logic                       rxPopEff;
    logic                       rxFrameErr;
    logic                       rxOverrun;

    assign stopSample       = (rxState == STOP) && (rxCnt == LAST_CNT);
    assign rxPush           = stopSample && rxSync;
    assign rxPopEff         = cpu_rden_in && !rxEmpty;
    assign cpu_valid_out    = !rxEmpty;
    assign cpu_data_out     = rxEmpty ? 8'h00 : rxHead;
    assign rx_frame_err_out = rxFrameErr;
    assign rx_overrun_out   = rxOverrun;

    sync_fifo #(.W(8), .AW(FIFO_AW)) rxFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (rxPush),
        .pushData (rxShift),
        .pop      (cpu_rden_in),
        .popData  (rxHead),
        .full     (rxFull),
        .empty    (rxEmpty),
        .count    (unusedRxCount)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxMeta <= LINE_IDLE;
            rxSync <= LINE_IDLE;
            rxPrev <= LINE_IDLE;
        end else begin
            rxMeta <= uart_rx_in;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxState    <= IDLE;
            rxCnt      <= '0;
            rxIdx      <= '0;
            rxShift    <= '0;
            rxFrameErr <= 1'b0;
            rxOverrun  <= 1'b0;
        end else begin
            rxFrameErr <= stopSample && !rxSync;
            rxOverrun  <= stopSample && rxSync && rxFull && !rxPopEff;
            case (rxState)
                IDLE: begin
                    // The edge is seen one cycle late, so the count starts at 1.
                    if (rxPrev && !rxSync) begin
                        rxCnt   <= CW'(1);
                        rxState <= START;
                    end
                end
                START: begin
                    if (rxCnt == HALF_CNT) begin
                        rxCnt   <= '0;
                        rxIdx   <= '0;
                        rxState <= rxSync ? IDLE : DATA;
                    end else begin
                        rxCnt <= rxCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (rxCnt == LAST_CNT) begin
                        rxCnt   <= '0;
                        rxShift <= {rxSync, rxShift[UART_DATA_BITS-1:1]};
                        if (rxIdx == LAST_IDX) begin
                            rxState <= STOP;
                        end else begin
                            rxIdx <= rxIdx + IW'(1);
                        end
                    end else begin
                        rxCnt <= rxCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (rxCnt == LAST_CNT) begin
                        rxCnt   <= '0;
                        rxState <= IDLE;
                    end else begin
                        rxCnt <= rxCnt + CW'(1);
                    end
                end
                default: rxState <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
Peripheral-side responder for the processor's serial IO port, which data_memory drives through serial_out, serial_wren_out and serial_rden_out. It buffers bytes written by the processor in a TX FIFO and shifts them out as 8N1 UART frames. It receives 8N1 frames into an RX FIFO and presents them back to the processor as serial_in and serial_valid_in. It sits at the top level between the processor and the board UART pins.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range is 4 or more.
FIFO_AW, 4, log2 FIFO depth; depth is 2**FIFO_AW and applies to both TX and RX.

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
cpu_data_in  input  8  byte from the processor (its serial_out)
cpu_wren_in  input  1  processor write strobe, one byte per cycle high (its serial_wren_out)
cpu_ready_out  output  1  TX FIFO not full (to its serial_ready_in)
cpu_data_out  output  8  RX FIFO head byte (to its serial_in)
cpu_valid_out  output  1  RX FIFO not empty (to its serial_valid_in)
cpu_rden_in  input  1  processor pop strobe (its serial_rden_out)
uart_rx_in  input  1  asynchronous UART receive line, idle high
uart_tx_out  output  1  UART transmit line, idle high
rx_frame_err_out  output  1  one-cycle pulse when a received stop bit is 0
rx_overrun_out  output  1  one-cycle pulse when a received byte is dropped because the RX FIFO is full

Behaviour:
Reset (reset=0, asynchronous):
- Both FIFOs are emptied.
- Both FSMs go to IDLE.
- uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, cpu_data_out=0, both error pulses 0.
- Reset asserted mid-frame aborts the frame immediately; the line returns high the same cycle.

CPU write side:
- A push occurs on a rising edge where cpu_wren_in=1 and cpu_ready_out=1.
- A write while the FIFO is full is silently discarded.
- cpu_ready_out is registered from the FIFO count and falls the cycle after the push that fills the FIFO.

CPU read side:
- The RX FIFO is first-word-fall-through: cpu_data_out shows the head byte whenever cpu_valid_out=1.
- cpu_rden_in=1 with cpu_valid_out=1 pops the head; the next byte appears on the following cycle.
- cpu_rden_in while the FIFO is empty is ignored.

TX FSM, states IDLE, START, DATA, STOP, with a bit counter of 0..CLKS_PER_BIT-1 and a bit index of 0..7:
- IDLE: when the FIFO is not empty, pop into the shift register and go to START.
- Each of START, DATA and STOP holds its line value for exactly CLKS_PER_BIT cycles.
- Line values: START=0, DATA=LSB first, STOP=1.
- After STOP, return to IDLE.
- Back-to-back frames: if the FIFO is not empty at the end of STOP, the next START follows with exactly one IDLE cycle.
- Latency: a write into an empty FIFO with TX idle at edge N drives uart_tx_out low from edge N+2.

RX FSM, states IDLE, START, DATA, STOP:
- uart_rx_in passes through a 2-flop synchronizer; all references below use the synchronized value.
- IDLE: on a falling edge (1 to 0), go to START.
- START: at CLKS_PER_BIT/2 (integer divide) re-check the line. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
- STOP: one sample, then:
  - stop=1 and FIFO not full: push the byte.
  - stop=1 and FIFO full: drop the byte and pulse rx_overrun_out.
  - stop=0: drop the byte and pulse rx_frame_err_out.
  In all cases go to IDLE.
- A pushed byte is visible on cpu_valid_out/cpu_data_out the cycle after the stop-bit sample edge.
- Full FIFO with a simultaneous pop and push: the pop is applied first, so the push succeeds and there is no overrun.

FIFO arithmetic:
- Read and write pointers are FIFO_AW bits and wrap modulo depth.
- The count is FIFO_AW+1 bits.
- full is count==depth; empty is count==0.

Decomposition:
- Package serial_uart_pkg holds:
  - the enum uart_state_t {IDLE, START, DATA, STOP}, shared by both FSMs;
  - constants UART_DATA_BITS=8, LINE_IDLE=1'b1.
- One sub-module, sync_fifo (parameters W and AW; first-word-fall-through; push/pop/full/empty/count), instantiated twice with W=8, AW=FIFO_AW.
- The TX and RX FSMs stay inline in serial_uart_bridge.

Test Plan (run with CLKS_PER_BIT=4, FIFO_AW=2):
1. Reset release, write 0xA5 -> uart_tx_out low from edge N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; cpu_ready_out stays 1.
2. Write 5 bytes 0x01..0x05 on consecutive cycles with TX busy -> cpu_ready_out falls after the 4th accepted push. The 5th byte is discarded and the line carries 0x01..0x04 only. Each gap between frames is 1 idle cycle.
3. Drive an 8N1 frame of 0x3C on uart_rx_in -> cpu_valid_out=1 and cpu_data_out=0x3C one cycle after the stop sample; a cpu_rden_in pulse then makes cpu_valid_out=0.
4. Receive 5 frames without popping -> 4 bytes are stored, rx_overrun_out pulses once on the 5th, and the FIFO holds the first 4 bytes in order.
5. Send a frame of 0x55 with the stop bit forced to 0 -> rx_frame_err_out pulses once and cpu_valid_out stays 0. Separately, a 1-cycle low glitch on the idle line returns the FSM to IDLE with no push.
6. Assert reset mid-TX-frame and mid-RX-frame -> uart_tx_out=1 immediately, both FIFOs are empty, cpu_ready_out=1, and after release a fresh 0x7E transmits correctly.
